// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage load-use hazard controller: per-register countdown scoreboard,
// memory-busy freeze, branch-flush override and saturating stall counter.
module hazard_scoreboard_ctrl #(
   parameter int          REG_W       = 4,
   parameter int          LOAD_LAT    = 1,
   parameter logic [15:0] SRC2_IGNORE = 16'hFF74,
   parameter bit          ZERO_REG_EN = 1'b1,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [3:0]       id_opcode,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_mem_read,
   input  logic [REG_W-1:0] id_dst,
   input  logic             mem_busy,
   input  logic             flush,
   output logic             stall_en,
   output logic             bubble_en,
   output logic [CNT_W-1:0] hazard_cnt
);

   localparam int         NREG = 2 ** REG_W;
   localparam logic [2:0] LAT3 = 3'(LOAD_LAT);

   logic [2:0]       sb_q [NREG];
   logic [2:0]       sb_d [NREG];
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   logic use1;
   logic use2;
   logic pend1;
   logic pend2;
   logic lu_haz;
   logic issue;
   logic ld_set;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + 1'b1;
   endfunction

   function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
      return ZERO_REG_EN && (r == '0);
   endfunction

   // Hazard detection and pipeline control outputs
   always_comb begin
      use1      = id_valid;
      use2      = id_valid & ~SRC2_IGNORE[id_opcode];
      pend1     = (sb_q[id_src1] != 3'd0) & ~is_zero_reg(id_src1);
      pend2     = (sb_q[id_src2] != 3'd0) & ~is_zero_reg(id_src2);
      lu_haz    = ~flush & ((use1 & pend1) | (use2 & pend2));
      stall_en  = lu_haz | mem_busy;
      bubble_en = lu_haz & ~mem_busy;
      issue     = id_valid & ~flush & ~lu_haz & ~mem_busy;
      ld_set    = issue & id_mem_read & ~is_zero_reg(id_dst);
   end

   // Scoreboard next state: a fresh load overrides the countdown of its entry
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         sb_d[r] = sb_q[r];
         if (!mem_busy) begin
            if (ld_set && (id_dst == REG_W'(r))) begin
               sb_d[r] = LAT3;
            end else if (sb_q[r] != 3'd0) begin
               sb_d[r] = sb_q[r] - 3'd1;
            end
         end
      end
      cnt_d = bubble_en ? sat_inc(cnt_q) : cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            sb_q[r] <= 3'd0;
         end
         cnt_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            sb_q[r] <= sb_d[r];
         end
         cnt_q <= cnt_d;
      end
   end

   assign hazard_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Bench: three controllers (LOAD_LAT 1/2/3, the first with a 2-bit counter)
// share one stimulus stream and are compared against a timestamp model.
module tb_hazard_scoreboard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [3:0] id_opcode;
   logic [3:0] id_src1;
   logic [3:0] id_src2;
   logic       id_mem_read;
   logic [3:0] id_dst;
   logic       mem_busy;
   logic       flush;
   logic       st1, st2, st3;
   logic       bb1, bb2, bb3;
   logic [1:0]  cnt1;
   logic [15:0] cnt2, cnt3;

   always #5 clk = ~clk;

   hazard_scoreboard_ctrl #(.LOAD_LAT(1), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_src1(id_src1), .id_src2(id_src2), .id_mem_read(id_mem_read),
      .id_dst(id_dst), .mem_busy(mem_busy), .flush(flush),
      .stall_en(st1), .bubble_en(bb1), .hazard_cnt(cnt1));
   hazard_scoreboard_ctrl #(.LOAD_LAT(2), .CNT_W(16)) u2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_src1(id_src1), .id_src2(id_src2), .id_mem_read(id_mem_read),
      .id_dst(id_dst), .mem_busy(mem_busy), .flush(flush),
      .stall_en(st2), .bubble_en(bb2), .hazard_cnt(cnt2));
   hazard_scoreboard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_src1(id_src1), .id_src2(id_src2), .id_mem_read(id_mem_read),
      .id_dst(id_dst), .mem_busy(mem_busy), .flush(flush),
      .stall_en(st3), .bubble_en(bb3), .hazard_cnt(cnt3));

   typedef struct {
      logic       v;
      logic [3:0] op;
      logic [3:0] s1;
      logic [3:0] s2;
      logic       mr;
      logic [3:0] dst;
      logic       busy;
      logic       fl;
      logic [2:0] est;
      logic [2:0] eb;
   } vec_t;

   localparam logic [15:0] IGN = 16'hFF74;

   int total = 0;
   int bad   = 0;
   int tick;
   int ready [3][16];
   int cnt_m [3];
   int lat   [3] = '{1, 2, 3};
   int cmax  [3] = '{3, 65535, 65535};
   logic [2:0] obs_st;
   logic [2:0] obs_bb;
   vec_t tab[$];

   function automatic void chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endfunction

   function automatic vec_t mk(bit v, int op, int s1, int s2, bit mr, int dst,
                               bit busy, bit fl, logic [2:0] est, logic [2:0] eb);
      vec_t x;
      x.v = v; x.op = 4'(op); x.s1 = 4'(s1); x.s2 = 4'(s2); x.mr = mr;
      x.dst = 4'(dst); x.busy = busy; x.fl = fl; x.est = est; x.eb = eb;
      return x;
   endfunction

   function automatic int dut_cnt(int k);
      if (k == 0) return int'(cnt1);
      if (k == 1) return int'(cnt2);
      return int'(cnt3);
   endfunction

   // A register has an outstanding load while the non-frozen cycle count is below its ready time.
   function automatic bit pend_m(int k, int r);
      if (r == 0) return 1'b0;
      return tick < ready[k][r];
   endfunction

   function automatic void model_reset();
      tick = 0;
      for (int k = 0; k < 3; k++) begin
         cnt_m[k] = 0;
         for (int r = 0; r < 16; r++) ready[k][r] = 0;
      end
   endfunction

   task automatic step(input vec_t x, input string tag);
      bit haz, iss [3], bub [3];
      @(negedge clk);
      id_valid = x.v; id_opcode = x.op; id_src1 = x.s1; id_src2 = x.s2;
      id_mem_read = x.mr; id_dst = x.dst; mem_busy = x.busy; flush = x.fl;
      #1;
      obs_st = {st3, st2, st1};
      obs_bb = {bb3, bb2, bb1};
      for (int k = 0; k < 3; k++) begin
         haz = !x.fl && ((x.v && pend_m(k, int'(x.s1))) ||
                         (x.v && !IGN[x.op] && pend_m(k, int'(x.s2))));
         chk($sformatf("%s stall L%0d", tag, lat[k]), int'(obs_st[k]), int'(haz || x.busy));
         chk($sformatf("%s bubble L%0d", tag, lat[k]), int'(obs_bb[k]), int'(haz && !x.busy));
         chk($sformatf("%s cnt L%0d", tag, lat[k]), dut_cnt(k), cnt_m[k]);
         iss[k] = x.v && !x.fl && !haz && !x.busy;
         bub[k] = haz && !x.busy;
      end
      if (!x.busy) begin
         tick++;
         for (int k = 0; k < 3; k++)
            if (iss[k] && x.mr && x.dst != 4'd0) ready[k][x.dst] = tick + lat[k];
      end
      for (int k = 0; k < 3; k++)
         if (bub[k] && cnt_m[k] < cmax[k]) cnt_m[k]++;
   endtask

   initial begin
      vec_t ld9, use9;
      // Directed table: each row's expected stall/bubble bits are {L3, L2, L1}.
      tab.push_back(mk(1, 0, 1, 2, 1, 3, 0, 0, 3'b000, 3'b000)); // load R3
      tab.push_back(mk(1, 0, 3, 4, 0, 5, 0, 0, 3'b111, 3'b111)); // ADD R5,R3,R4
      tab.push_back(mk(1, 0, 3, 4, 0, 5, 0, 0, 3'b110, 3'b110));
      tab.push_back(mk(1, 0, 3, 4, 0, 5, 0, 0, 3'b100, 3'b100));
      tab.push_back(mk(1, 0, 3, 4, 0, 5, 0, 0, 3'b000, 3'b000));
      tab.push_back(mk(1, 0, 0, 0, 1, 7, 0, 0, 3'b000, 3'b000)); // load R7
      tab.push_back(mk(1, 4, 7, 7, 0, 2, 0, 0, 3'b111, 3'b111)); // SLL R2,R7
      tab.push_back(mk(1, 4, 7, 7, 0, 2, 0, 0, 3'b110, 3'b110));
      tab.push_back(mk(1, 4, 7, 7, 0, 2, 0, 0, 3'b100, 3'b100));
      tab.push_back(mk(1, 4, 7, 7, 0, 2, 0, 0, 3'b000, 3'b000));
      tab.push_back(mk(1, 0, 0, 0, 1, 7, 0, 0, 3'b000, 3'b000)); // load R7
      tab.push_back(mk(1, 2, 1, 7, 0, 3, 0, 0, 3'b000, 3'b000)); // XOR src2 ignored
      tab.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 3'b000, 3'b000)); // load R0
      tab.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 3'b000, 3'b000)); // ADD R1,R0,R0
      tab.push_back(mk(1, 0, 0, 0, 1, 4, 0, 0, 3'b000, 3'b000)); // load R4
      tab.push_back(mk(1, 0, 4, 5, 0, 1, 0, 0, 3'b111, 3'b111));
      tab.push_back(mk(1, 0, 4, 5, 0, 1, 1, 0, 3'b111, 3'b000)); // busy freeze
      tab.push_back(mk(1, 0, 4, 5, 0, 1, 1, 0, 3'b111, 3'b000));
      tab.push_back(mk(1, 0, 4, 5, 0, 1, 0, 0, 3'b110, 3'b110));
      tab.push_back(mk(1, 0, 4, 5, 0, 1, 0, 0, 3'b100, 3'b100));
      tab.push_back(mk(1, 0, 4, 5, 0, 1, 0, 0, 3'b000, 3'b000));
      tab.push_back(mk(1, 0, 0, 0, 1, 6, 0, 0, 3'b000, 3'b000)); // load R6
      tab.push_back(mk(1, 0, 6, 0, 0, 1, 0, 1, 3'b000, 3'b000)); // flushed dependent
      tab.push_back(mk(1, 0, 6, 0, 0, 1, 0, 0, 3'b110, 3'b110));
      tab.push_back(mk(1, 0, 6, 0, 0, 1, 0, 0, 3'b100, 3'b100));
      tab.push_back(mk(1, 0, 6, 0, 0, 1, 0, 0, 3'b000, 3'b000));

      id_valid = 0; id_opcode = 0; id_src1 = 0; id_src2 = 0;
      id_mem_read = 0; id_dst = 0; mem_busy = 0; flush = 0;
      rst = 1'b1;
      model_reset();
      #1;
      chk("reset stall", int'({st3, st2, st1}), 0);
      chk("reset bubble", int'({bb3, bb2, bb1}), 0);
      repeat (2) @(posedge clk);
      chk("reset cnt L3", int'(cnt3), 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tab[i]) begin
         step(tab[i], $sformatf("row%0d", i));
         chk($sformatf("row%0d tab stall", i), int'(obs_st), int'(tab[i].est));
         chk($sformatf("row%0d tab bubble", i), int'(obs_bb), int'(tab[i].eb));
      end
      @(negedge clk);
      chk("table cnt L1", int'(cnt1), 3);
      chk("table cnt L2", int'(cnt2), 7);
      chk("table cnt L3", int'(cnt3), 11);

      // Fourth bubble on the 2-bit counter must saturate.
      ld9  = mk(1, 0, 0, 0, 1, 9, 0, 0, 3'b000, 3'b000);
      use9 = mk(1, 0, 9, 0, 0, 1, 0, 0, 3'b000, 3'b000);
      step(ld9, "sat load");
      step(use9, "sat use");
      @(negedge clk);
      #1;
      chk("sat cnt L1", int'(cnt1), 3);
      chk("sat cnt L3", int'(cnt3), 12);

      // Asynchronous reset in the middle of an L3 countdown.
      chk("pre-rst stall L3", int'(st3), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid-rst stall L3", int'(st3), 0);
      chk("mid-rst cnt L3", int'(cnt3), 0);
      chk("mid-rst cnt L1", int'(cnt1), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(use9, "post-rst use");
      chk("post-rst stall", int'(obs_st), 0);

      for (int i = 0; i < 800; i++) begin
         vec_t x;
         x.v    = ($urandom_range(0, 9) != 0);
         x.op   = 4'($urandom_range(0, 15));
         x.s1   = 4'($urandom_range(0, 7));
         x.s2   = 4'($urandom_range(0, 7));
         x.mr   = ($urandom_range(0, 2) == 0);
         x.dst  = 4'($urandom_range(0, 7));
         x.busy = ($urandom_range(0, 7) == 0);
         x.fl   = ($urandom_range(0, 7) == 0);
         x.est  = 3'b000;
         x.eb   = 3'b000;
         step(x, $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
